// File: rtl/config_pkg.sv
// Core configuration record consumed by the custom vector loader.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned CustomVecNumWords;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, CustomVecNumWords: 8};

endpackage

// File: rtl/custom_vec_pkg.sv
// Shared FSM state encoding and handshake payload types for the vector loader.
package custom_vec_pkg;

    // Wide enough to count 0..4 requests in flight.
    localparam int unsigned OUT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vec_state_e;

    // Memory request handshake as seen by the bookkeeping counters.
    typedef struct packed {
        logic valid;
        logic ready;
    } vec_req_hs_t;

    // Classified response event: valid only while a transfer is active.
    typedef struct packed {
        logic valid;
        logic err;
    } vec_rsp_t;

    // Width of a word-count field able to hold 0..n.
    function automatic int unsigned len_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/custom_vec_loader_ctr.sv
// Issued / received / outstanding bookkeeping for one load transfer.
module custom_vec_loader_ctr
    import custom_vec_pkg::*;
#(
    parameter int unsigned LenW = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr,
    input  vec_req_hs_t       req,
    input  logic              rsp,
    output logic [LenW-1:0]   issued,
    output logic [LenW-1:0]   received,
    output logic [OUT_W-1:0]  outstanding
);

    logic issue;

    assign issue = req.valid & req.ready;

    // Counters restart on command acceptance; issue and response in one cycle cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
        end else if (clr) begin
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
        end else begin
            issued      <= issued + LenW'(issue);
            received    <= received + LenW'(rsp);
            outstanding <= outstanding + OUT_W'(issue) - OUT_W'(rsp);
        end
    end

endmodule

// File: rtl/custom_vec_loader.sv
// Custom vector loader: reads cmd_len_i XLEN words from memory into vector storage.
// Optional busy-cycle performance counter enabled by CUSTOM_VEC_LOADER_PERF_EN.
module custom_vec_loader
    import custom_vec_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NumWords       = CVA6Cfg.CustomVecNumWords,
    parameter int unsigned           MaxOutstanding = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [CVA6Cfg.XLEN-1:0]       cmd_addr_i,
    input  logic [$clog2(NumWords):0]     cmd_len_i,
    input  logic [$clog2(NumWords)-1:0]   cmd_dst_i,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    output logic [CVA6Cfg.XLEN-1:0]       req_addr_o,
    input  logic                          rsp_valid_i,
    input  logic [CVA6Cfg.XLEN-1:0]       rsp_data_i,
    input  logic                          rsp_err_i,
    output logic                          vwe_o,
    output logic [$clog2(NumWords)-1:0]   vwaddr_o,
    output logic [CVA6Cfg.XLEN-1:0]       vwdata_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [31:0]                   busy_cycles_o
);

    localparam int unsigned XLEN  = CVA6Cfg.XLEN;
    localparam int unsigned IDX_W = $clog2(NumWords);
    localparam int unsigned LEN_W = len_width(NumWords);
    localparam int unsigned SUM_W = LEN_W + 1;
    localparam int unsigned BYTES = XLEN / 8;

    vec_state_e          state;
    vec_state_e          state_nxt;
    logic [XLEN-1:0]     base_q;
    logic [LEN_W-1:0]    len_q;
    logic [IDX_W-1:0]    dst_q;
    logic                err_q;

    logic [LEN_W-1:0]    issued;
    logic [LEN_W-1:0]    received;
    logic [OUT_W-1:0]    outstanding;

    logic                accept;
    logic                active;
    vec_rsp_t            rsp_ev;
    vec_req_hs_t         req_hs;
    logic                rsp_ok;
    logic [SUM_W-1:0]    wr_sum;
    logic [IDX_W-1:0]    wr_idx;

    assign accept = cmd_valid_i && (state == IDLE);
    assign active = (state == ISSUE) || (state == DRAIN);

    // Responses outside an active transfer (idle, or stale after reset) are dropped here.
    assign rsp_ev       = '{valid: rsp_valid_i & active, err: rsp_err_i};
    assign rsp_ok       = rsp_ev.valid && !rsp_ev.err && !err_q;
    assign req_hs.valid = req_valid_o;
    assign req_hs.ready = req_ready_i;

    assign wr_sum = (SUM_W'(dst_q) + SUM_W'(received)) % SUM_W'(NumWords);
    assign wr_idx = IDX_W'(wr_sum);

    custom_vec_loader_ctr #(
        .LenW (LEN_W)
    ) u_ctr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr         (accept),
        .req         (req_hs),
        .rsp         (rsp_ev.valid),
        .issued      (issued),
        .received    (received),
        .outstanding (outstanding)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            len_q  <= '0;
            dst_q  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            base_q <= cmd_addr_i;
            len_q  <= cmd_len_i;
            dst_q  <= cmd_dst_i;
            err_q  <= 1'b0;
        end else if (rsp_ev.valid && rsp_ev.err) begin
            err_q  <= 1'b1;
        end
    end

    // Next-state logic; after an error, drain until nothing is in flight.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_len_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (rsp_ev.valid && rsp_ev.err) begin
                    state_nxt = DRAIN;
                end else if (issued == len_q) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (err_q) begin
                    if (outstanding == '0) begin
                        state_nxt = DONE;
                    end
                end else if (received == len_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode: request gating, storage write port and status.
    always_comb begin
        cmd_ready_o = 1'b0;
        req_valid_o = 1'b0;
        req_addr_o  = '0;
        vwe_o       = 1'b0;
        vwaddr_o    = '0;
        vwdata_o    = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;

        cmd_ready_o = (state == IDLE);
        busy_o      = (state != IDLE);

        if (state == ISSUE) begin
            req_valid_o = (issued < len_q) &&
                          (outstanding < OUT_W'(MaxOutstanding)) && !err_q;
            req_addr_o  = base_q + XLEN'(issued) * XLEN'(BYTES);
        end

        if (rsp_ok) begin
            vwe_o    = 1'b1;
            vwaddr_o = wr_idx;
            vwdata_o = rsp_data_i;
        end

        if (state == DONE) begin
            done_o = 1'b1;
            err_o  = err_q;
        end
    end

`ifdef CUSTOM_VEC_LOADER_PERF_EN
    logic [31:0] busy_cnt_q;

    // Saturating count of busy cycles, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_cnt_q <= '0;
        end else if ((state != IDLE) && (busy_cnt_q != '1)) begin
            busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign busy_cycles_o = busy_cnt_q;
`else
    assign busy_cycles_o = '0;
`endif

endmodule

// File: tb/tb_custom_vec_loader.sv
// Self-checking bench for custom_vec_loader with a transaction-level model.
module tb_custom_vec_loader;

    localparam int NW   = 8;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [2:0]  cmd_dst = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [63:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        vwe;
    logic [2:0]  vwaddr;
    logic [63:0] vwdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] busy_cycles;

    custom_vec_loader #(.MaxOutstanding(MAXO)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_addr_i    (cmd_addr),
        .cmd_len_i     (cmd_len),
        .cmd_dst_i     (cmd_dst),
        .req_valid_o   (req_valid),
        .req_ready_i   (req_ready),
        .req_addr_o    (req_addr),
        .rsp_valid_i   (rsp_valid),
        .rsp_data_i    (rsp_data),
        .rsp_err_i     (rsp_err),
        .vwe_o         (vwe),
        .vwaddr_o      (vwaddr),
        .vwdata_o      (vwdata),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .busy_cycles_o (busy_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          due;
        int          gen;
    } ent_t;

    ent_t        rq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Model of the active transfer.
    bit          m_active = 1'b0;
    bit          m_err = 1'b0;
    logic [63:0] m_base = '0;
    int          m_len = 0, m_dst = 0, m_iss = 0, m_recv = 0, m_out = 0, m_gen = 0;
    int          m_err_at = -1;
    int          acc_cyc = 0, done_cnt = 0, done_lat = 0, n_req = 0, max_out = 0;
    int          busy_cnt = 0;
    bit          last_err = 1'b0;
    int          wr_idx[$];
    logic [63:0] req_addrs[$];

    // Stimulus knobs and responder state.
    int          lat = 1, stall_req = 0, stalled_seen = 0, rsp_tag = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_addr = '0;

    logic [63:0] exp_addr;
    bit          allowed;
    int          k;
    ent_t        ent;

    function automatic logic [63:0] data_of(input logic [63:0] a);
        return {a[31:0] ^ 32'hC3C3_5A5A, ~a[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("rst_req_valid", 64'(req_valid), 64'd0);
            chk("rst_req_addr", req_addr, 64'd0);
            chk("rst_vwe", 64'(vwe), 64'd0);
            chk("rst_vwaddr", 64'(vwaddr), 64'd0);
            chk("rst_vwdata", vwdata, 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_err", 64'(err), 64'd0);
            chk("rst_busy_cycles", 64'(busy_cycles), 64'd0);
            m_active   = 1'b0;
            m_err      = 1'b0;
            m_iss      = 0;
            m_recv     = 0;
            m_out      = 0;
            busy_cnt   = 0;
            prev_stall = 1'b0;
            m_gen++;
        end else begin
`ifdef CUSTOM_VEC_LOADER_PERF_EN
            chk("busy_cycles", 64'(busy_cycles), 64'(busy_cnt));
`else
            chk("busy_cycles", 64'(busy_cycles), 64'd0);
`endif
            chk("busy", 64'(busy), 64'(m_active));
            chk("cmd_ready", 64'(cmd_ready), 64'(!m_active));
            if (m_active) busy_cnt++;

            if (req_valid) begin
                allowed  = m_active && (m_iss < m_len) && (m_out < MAXO) && !m_err;
                exp_addr = m_base + 64'(m_iss) * 64'd8;
                chk("req_allowed", 64'(allowed), 64'd1);
                chk("req_addr", req_addr, exp_addr);
                if (prev_stall) chk("req_stable", req_addr, prev_addr);
                if (req_ready) begin
                    ent.data = data_of(req_addr);
                    ent.err  = (m_iss == m_err_at);
                    ent.due  = cyc + lat;
                    ent.gen  = m_gen;
                    rq.push_back(ent);
                    req_addrs.push_back(req_addr);
                    m_iss++;
                    m_out++;
                    n_req++;
                    if (m_out > max_out) max_out = m_out;
                    chk("outstanding_limit", 64'(m_out <= MAXO), 64'd1);
                    prev_stall = 1'b0;
                end else begin
                    stalled_seen++;
                    prev_stall = 1'b1;
                    prev_addr  = req_addr;
                end
            end else begin
                if (prev_stall) chk("req_hold", 64'd0, 64'd1);
                prev_stall = 1'b0;
            end

            if (rsp_valid && m_active && (rsp_tag == m_gen)) begin
                k = m_recv;
                if (!m_err && !rsp_err) begin
                    chk("vwe", 64'(vwe), 64'd1);
                    chk("vwaddr", 64'(vwaddr), 64'((m_dst + k) % NW));
                    chk("vwdata", vwdata, data_of(m_base + 64'(k) * 64'd8));
                    wr_idx.push_back(int'(vwaddr));
                end else begin
                    chk("vwe_suppressed", 64'(vwe), 64'd0);
                    if (rsp_err) m_err = 1'b1;
                end
                m_recv++;
                m_out--;
            end else begin
                chk("vwe_idle", 64'(vwe), 64'd0);
            end

            if (done) begin
                chk("done_active", 64'(m_active), 64'd1);
                chk("done_err", 64'(err), 64'(m_err));
                chk("done_complete",
                    64'((m_recv == m_iss) && (m_err || (m_recv == m_len))), 64'd1);
                done_cnt++;
                done_lat = cyc - acc_cyc;
                last_err = err;
                m_active = 1'b0;
            end else begin
                chk("err_low", 64'(err), 64'd0);
            end

            if (cmd_valid && cmd_ready) begin
                m_active   = 1'b1;
                m_err      = 1'b0;
                m_base     = cmd_addr;
                m_len      = int'(cmd_len);
                m_dst      = int'(cmd_dst);
                m_iss      = 0;
                m_recv     = 0;
                m_out      = 0;
                n_req      = 0;
                max_out    = 0;
                acc_cyc    = cyc;
                prev_stall = 1'b0;
                wr_idx.delete();
                req_addrs.delete();
            end
        end
    end

    // In-order memory responder with fixed latency and optional initial stall.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            req_ready = (stalled_seen >= stall_req);
            if ((rq.size() > 0) && (rq[0].due <= cyc + 1)) begin
                ent       = rq.pop_front();
                rsp_valid = 1'b1;
                rsp_data  = ent.data;
                rsp_err   = ent.err;
                rsp_tag   = ent.gen;
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
                rsp_err   = 1'b0;
            end
        end
    end

    task automatic start_cmd(input logic [63:0] a, input int l, input int d,
                             input int ea, input int lt, input int st);
        m_err_at     = ea;
        lat          = lt;
        stall_req    = st;
        stalled_seen = 0;
        @(posedge clk);
        #1;
        cmd_addr  = a;
        cmd_len   = 4'(l);
        cmd_dst   = 3'(d);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [63:0] a, input int l, input int d,
                           input int ea, input int lt, input int st);
        int d0;
        int t;
        d0 = done_cnt;
        start_cmd(a, l, d, ea, lt, st);
        t = 0;
        while ((done_cnt == d0) && (t < 300)) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_finished"}, 64'(done_cnt != d0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_single_done"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic 4-word load, back-to-back memory.
        run_cmd("t1", 64'h8000_0000, 4, 0, -1, 1, 0);
        chk("t1_nreq", 64'(n_req), 64'd4);
        chk("t1_addr0", req_addrs[0], 64'h8000_0000);
        chk("t1_addr1", req_addrs[1], 64'h8000_0008);
        chk("t1_addr2", req_addrs[2], 64'h8000_0010);
        chk("t1_addr3", req_addrs[3], 64'h8000_0018);
        chk("t1_nwr", 64'(wr_idx.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_widx", 64'(wr_idx[i]), 64'(i));
        chk("t1_err", 64'(last_err), 64'd0);
        chk("t1_latency", 64'(done_lat), 64'd7);

        // Destination wraps past the last storage word.
        run_cmd("t2", 64'h0000_2000, 3, NW - 1, -1, 1, 0);
        chk("t2_nwr", 64'(wr_idx.size()), 64'd3);
        chk("t2_widx0", 64'(wr_idx[0]), 64'd7);
        chk("t2_widx1", 64'(wr_idx[1]), 64'd0);
        chk("t2_widx2", 64'(wr_idx[2]), 64'd1);

        // Zero-length command completes without requests.
        run_cmd("t3", 64'h0000_3000, 0, 2, -1, 1, 0);
        chk("t3_nreq", 64'(n_req), 64'd0);
        chk("t3_latency", 64'(done_lat), 64'd1);
        chk("t3_err", 64'(last_err), 64'd0);

        // Error on the second response.
        run_cmd("t4", 64'h8000_0000, 4, 0, 1, 1, 0);
        chk("t4_nreq", 64'(n_req), 64'd3);
        chk("t4_nwr", 64'(wr_idx.size()), 64'd1);
        chk("t4_widx0", 64'(wr_idx[0]), 64'd0);
        chk("t4_err", 64'(last_err), 64'd1);
        chk("t4_latency", 64'(done_lat), 64'd6);

        // Stalled first request, slow memory pushes the outstanding limit.
        run_cmd("t5", 64'h8000_0000, 4, 0, -1, 3, 5);
        chk("t5_stalls", 64'(stalled_seen), 64'd5);
        chk("t5_nreq", 64'(n_req), 64'd4);
        chk("t5_addr0", req_addrs[0], 64'h8000_0000);
        chk("t5_max_out", 64'(max_out), 64'(MAXO));
        chk("t5_nwr", 64'(wr_idx.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t5_widx", 64'(wr_idx[i]), 64'(i));
        chk("t5_err", 64'(last_err), 64'd0);

        // Reset in the middle of a transfer; stale responses land while idle.
        start_cmd(64'h0000_4000, 4, 0, -1, 6, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_stale_drained", 64'(rq.size()), 64'd0);
        run_cmd("t6", 64'h0000_1000, 2, 3, -1, 1, 0);
        chk("t6_nwr", 64'(wr_idx.size()), 64'd2);
        chk("t6_widx0", 64'(wr_idx[0]), 64'd3);
        chk("t6_widx1", 64'(wr_idx[1]), 64'd4);
        chk("t6_latency", 64'(done_lat), 64'd5);
`ifdef CUSTOM_VEC_LOADER_PERF_EN
        chk("t6_busy_cycles", 64'(busy_cycles), 64'd5);
`else
        chk("t6_busy_cycles", 64'(busy_cycles), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
